multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Parametrised multi-cycle control unit for the accumulator processor; successor to the single-cycle combinational decoder. It captures one instruction at a time from the fetch unit and sequences it through decode, execute, optional data-memory access and retire. Along the way it issues datapath strobes, runs a request/acknowledge handshake with data memory, and drives the program-counter advance/jump. It sits between instruction ROM/fetch, the ALU/register file and data memory. Opcode names come from the `definitions` package.

## Interface
Parameters:
- IW, 9: instruction width; opcode is Instruction[IW-1:IW-4], mode bit is Instruction[IW-5].
- MEM_TIMEOUT, 15: max cycles waiting for mem_ack (1..255).
- CNT_W, 16: retired-instruction counter width.

Ports:
- CLK, in, 1: clock; single clock domain, all state changes on rising edge.
- Reset, in, 1: asynchronous, active-low reset.
- Instruction, in, IW: machine code from fetch.
- instr_valid, in, 1: Instruction is valid.
- instr_ready, out, 1: controller can accept an instruction.
- ZERO, in, 1: ALU result = 0.
- BEVEN, in, 1: ALU input B is even.
- NEG, in, 1: ALU result is negative.
- mem_ack, in, 1: data memory completed the request.
- mem_req, out, 1: data memory request.
- jump_en, out, 1: program counter loads the branch/jump target.
- pc_advance, out, 1: program counter increments.
- sc_en, sc_clr, out, 1 each: carry register enable and clear.
- reg_exe, imm_exe, out, 1 each: register-source ALU op and immediate-source ALU op.
- mem_to_reg, reg_to_mem, out, 1 each: load writeback and store drive.
- reg_to_acc, acc_to_reg, assign_val, out, 1 each: move and assign strobes.
- err, out, 1: sticky memory-timeout error.
- retired, out, CNT_W: count of retired instructions.

## Operation
- States: IDLE, DECODE, EXEC, MEM, WB, RETIRE, ERR.
- Internal registers: instruction register IR, wait counter, retired counter.

State transitions:
- IDLE: instr_ready=1. When instr_valid=1, capture IR and go to DECODE; otherwise hold.
- DECODE: no strobes. Always go to EXEC.
- EXEC: issue the strobes decoded from IR (opcode and mode bit m).
  - ADD, SUB: reg_exe=!m, imm_exe=m, sc_en=1.
  - AND, OR: reg_exe=!m, imm_exe=m.
  - BEQ, BNE, BGE: reg_exe=!m, imm_exe=m. Latch the branch decision:
    - BEQ is taken when ZERO=1.
    - BNE is taken when ZERO=0.
    - BGE is taken when NEG=0.
  - MOV: reg_to_acc=!m, acc_to_reg=m.
  - ASSIGN: assign_val=1.
  - CLRSC: sc_clr=1.
  - JMP: always taken.
  - LW, SW: go to MEM. Every other opcode goes to RETIRE.
  - Undefined opcode: executes as a NOP and retires normally.
- MEM: mem_req=1. SW also holds reg_to_mem=1 for the whole state.
  - mem_ack=1: LW goes to WB, SW goes to RETIRE.
  - Wait counter reaches MEM_TIMEOUT without ack: go to ERR.
- WB: mem_to_reg=1 for one cycle, then go to RETIRE.
- RETIRE: exactly one of jump_en (taken) or pc_advance (otherwise) is 1. retired increments (wraps modulo 2^CNT_W). Go to IDLE.
- ERR: err=1 and all strobes are 0. Stays in ERR until Reset.

Rules that apply across states:
- ZERO, NEG and BEVEN are sampled only in EXEC. Flag values in any other state are ignored.
- mem_ack outside MEM is ignored.

## Timing
- Reset asserted: immediately, asynchronously, state=IDLE and IR=0. Every output is 0 except instr_ready=1. retired=0, err=0, wait counter=0.
- Reset asserted mid-instruction: the instruction is abandoned. No retire and no counter increment.
- All strobes are Moore outputs decoded from state and IR. Each is high for exactly one cycle, except mem_req and reg_to_mem, which hold for the whole of MEM.
- Latency, counting from the accept edge (cycle 0):
  - Non-memory instruction: DECODE in cycle 1, EXEC in cycle 2, RETIRE in cycle 3. instr_ready is high again in cycle 4.
  - LW with ack in its first MEM cycle: MEM in cycle 3, WB in cycle 4, RETIRE in cycle 5.
  - SW with ack in its first MEM cycle: MEM in cycle 3, RETIRE in cycle 4.
- mem_ack high in the first MEM cycle (same cycle as the rising mem_req) is accepted.
- Timeout: the wait counter clears on entry to MEM and increments each cycle without ack.
  - If ack arrives in the same cycle the counter reaches MEM_TIMEOUT, ack wins.
  - The ERR transition therefore occurs only after MEM_TIMEOUT full cycles with no ack.
- An instruction is presented back-to-back is accepted in the first IDLE cycle after RETIRE.

## Test plan
- Reset behaviour: assert Reset=0 mid-EXEC of an ADD -> next cycle is IDLE; all strobes 0, instr_ready=1, retired=0.
- Immediate ADD: ADD with m=1 accepted at cycle 0 -> imm_exe=1 and sc_en=1 in cycle 2; pc_advance in cycle 3; retired=1.
- Branches: BEQ with ZERO=1 in EXEC -> jump_en=1, pc_advance=0 at RETIRE. BNE with ZERO=1 -> pc_advance=1. ZERO toggling during DECODE does not change either outcome.
- LW with delayed ack: mem_ack after 3 MEM cycles -> mem_req high for exactly 3 cycles, then mem_to_reg for one cycle, then pc_advance.
- SW timeout: no mem_ack with MEM_TIMEOUT=4 -> ERR after 4 MEM cycles; err stays 1 and instr_valid is ignored until Reset.
- Counter wrap and throughput: CNT_W=2, five back-to-back ASSIGNs -> retired reads 1,2,3,0,1; each instruction takes exactly 4 cycles, accept to accept.

Source files
------------

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// multicycle_ctrl: sequences one instruction at a time through decode, execute,
// optional data-memory access and retire, driving registered datapath strobes.

package definitions;
  localparam logic [3:0] OP_ADD    = 4'h0;
  localparam logic [3:0] OP_SUB    = 4'h1;
  localparam logic [3:0] OP_AND    = 4'h2;
  localparam logic [3:0] OP_OR     = 4'h3;
  localparam logic [3:0] OP_BEQ    = 4'h4;
  localparam logic [3:0] OP_BNE    = 4'h5;
  localparam logic [3:0] OP_BGE    = 4'h6;
  localparam logic [3:0] OP_MOV    = 4'h7;
  localparam logic [3:0] OP_ASSIGN = 4'h8;
  localparam logic [3:0] OP_CLRSC  = 4'h9;
  localparam logic [3:0] OP_JMP    = 4'hA;
  localparam logic [3:0] OP_LW     = 4'hB;
  localparam logic [3:0] OP_SW     = 4'hC;
endpackage

module multicycle_ctrl
  import definitions::*;
#(
  parameter int IW          = 9,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic [IW-1:0]    Instruction,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic             ZERO,
  input  logic             BEVEN,
  input  logic             NEG,
  input  logic             mem_ack,
  output logic             mem_req,
  output logic             jump_en,
  output logic             pc_advance,
  output logic             sc_en,
  output logic             sc_clr,
  output logic             reg_exe,
  output logic             imm_exe,
  output logic             mem_to_reg,
  output logic             reg_to_mem,
  output logic             reg_to_acc,
  output logic             acc_to_reg,
  output logic             assign_val,
  output logic             err,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_RETIRE = 3'd5,
    S_ERR    = 3'd6
  } state_t;

  typedef struct packed {
    logic instr_ready;
    logic mem_req;
    logic jump_en;
    logic pc_advance;
    logic sc_en;
    logic sc_clr;
    logic reg_exe;
    logic imm_exe;
    logic mem_to_reg;
    logic reg_to_mem;
    logic reg_to_acc;
    logic acc_to_reg;
    logic assign_val;
  } strb_t;

  localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

  state_t           state_q, state_d;
  logic [IW-1:0]    ir_q, ir_d;
  logic [7:0]       wait_q, wait_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  strb_t            strb_q, strb_d;
  logic             err_q, err_d;
  logic [3:0]       op;
  logic             m;
  logic             taken;
  logic             unused_bits;

  assign op = ir_q[IW-1:IW-4];
  assign m  = ir_q[IW-5];
  // BEVEN and the operand field are consumed by the datapath, not by sequencing.
  assign unused_bits = ^{BEVEN, ir_q[IW-6:0]};

  // Strobes are computed for the state being entered, so each output is a
  // clean register that reflects the current state and IR.
  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    wait_d    = wait_q;
    retired_d = retired_q;
    err_d     = err_q;
    strb_d    = '0;
    taken     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (instr_valid) begin
          ir_d    = Instruction;
          state_d = S_DECODE;
        end else begin
          strb_d.instr_ready = 1'b1;
        end
      end
      S_DECODE: begin
        state_d = S_EXEC;
        case (op)
          OP_ADD, OP_SUB: begin
            strb_d.reg_exe = !m;
            strb_d.imm_exe = m;
            strb_d.sc_en   = 1'b1;
          end
          OP_AND, OP_OR, OP_BEQ, OP_BNE, OP_BGE: begin
            strb_d.reg_exe = !m;
            strb_d.imm_exe = m;
          end
          OP_MOV: begin
            strb_d.reg_to_acc = !m;
            strb_d.acc_to_reg = m;
          end
          OP_ASSIGN: strb_d.assign_val = 1'b1;
          OP_CLRSC:  strb_d.sc_clr     = 1'b1;
          default:   ;
        endcase
      end
      S_EXEC: begin
        case (op)
          OP_BEQ:  taken = ZERO;
          OP_BNE:  taken = !ZERO;
          OP_BGE:  taken = !NEG;
          OP_JMP:  taken = 1'b1;
          default: taken = 1'b0;
        endcase
        if (op == OP_LW || op == OP_SW) begin
          state_d           = S_MEM;
          wait_d            = '0;
          strb_d.mem_req    = 1'b1;
          strb_d.reg_to_mem = (op == OP_SW);
        end else begin
          state_d           = S_RETIRE;
          strb_d.jump_en    = taken;
          strb_d.pc_advance = !taken;
        end
      end
      S_MEM: begin
        if (mem_ack) begin
          if (op == OP_LW) begin
            state_d           = S_WB;
            strb_d.mem_to_reg = 1'b1;
          end else begin
            state_d           = S_RETIRE;
            strb_d.pc_advance = 1'b1;
          end
        end else if (wait_q + 8'd1 == TIMEOUT) begin
          state_d = S_ERR;
          err_d   = 1'b1;
        end else begin
          wait_d            = wait_q + 8'd1;
          strb_d.mem_req    = 1'b1;
          strb_d.reg_to_mem = (op == OP_SW);
        end
      end
      S_WB: begin
        state_d           = S_RETIRE;
        strb_d.pc_advance = 1'b1;
      end
      S_RETIRE: begin
        state_d            = S_IDLE;
        retired_d          = retired_q + 1'b1;
        strb_d.instr_ready = 1'b1;
      end
      S_ERR: begin
        err_d = 1'b1;
      end
      default: begin
        state_d            = S_IDLE;
        strb_d.instr_ready = 1'b1;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_q            <= S_IDLE;
      ir_q               <= '0;
      wait_q             <= '0;
      retired_q          <= '0;
      err_q              <= 1'b0;
      strb_q             <= '0;
      strb_q.instr_ready <= 1'b1;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      wait_q    <= wait_d;
      retired_q <= retired_d;
      err_q     <= err_d;
      strb_q    <= strb_d;
    end
  end

  assign instr_ready = strb_q.instr_ready;
  assign mem_req     = strb_q.mem_req;
  assign jump_en     = strb_q.jump_en;
  assign pc_advance  = strb_q.pc_advance;
  assign sc_en       = strb_q.sc_en;
  assign sc_clr      = strb_q.sc_clr;
  assign reg_exe     = strb_q.reg_exe;
  assign imm_exe     = strb_q.imm_exe;
  assign mem_to_reg  = strb_q.mem_to_reg;
  assign reg_to_mem  = strb_q.reg_to_mem;
  assign reg_to_acc  = strb_q.reg_to_acc;
  assign acc_to_reg  = strb_q.acc_to_reg;
  assign assign_val  = strb_q.assign_val;
  assign err         = err_q;
  assign retired     = retired_q;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// tb_multicycle_ctrl: table-driven instruction vectors with a retire scoreboard,
// plus hand sequences for reset, counter wrap/throughput and memory timeout.

module tb_multicycle_ctrl;
  import definitions::*;

  localparam int IW = 9;
  localparam int TO = 4;
  localparam int CW = 2;

  logic          CLK = 1'b0;
  logic          Reset = 1'b0;
  logic [IW-1:0] Instruction = '0;
  logic          instr_valid = 1'b0;
  logic          ZERO = 1'b0, BEVEN = 1'b0, NEG = 1'b0, mem_ack = 1'b0;
  logic          instr_ready, mem_req, jump_en, pc_advance, sc_en, sc_clr;
  logic          reg_exe, imm_exe, mem_to_reg, reg_to_mem, reg_to_acc, acc_to_reg;
  logic          assign_val, err;
  logic [CW-1:0] retired;
  logic [12:0]   outs;

  always #5 CLK = ~CLK;

  multicycle_ctrl #(.IW(IW), .MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .CLK(CLK), .Reset(Reset), .Instruction(Instruction), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .ZERO(ZERO), .BEVEN(BEVEN), .NEG(NEG), .mem_ack(mem_ack),
    .mem_req(mem_req), .jump_en(jump_en), .pc_advance(pc_advance), .sc_en(sc_en),
    .sc_clr(sc_clr), .reg_exe(reg_exe), .imm_exe(imm_exe), .mem_to_reg(mem_to_reg),
    .reg_to_mem(reg_to_mem), .reg_to_acc(reg_to_acc), .acc_to_reg(acc_to_reg),
    .assign_val(assign_val), .err(err), .retired(retired)
  );

  // Every output except instr_ready and retired, MSB first.
  assign outs = {mem_req, jump_en, pc_advance, sc_en, sc_clr, reg_exe, imm_exe,
                 mem_to_reg, reg_to_mem, reg_to_acc, acc_to_reg, assign_val, err};

  typedef struct {
    logic [3:0] op;
    logic       m;
    logic       zero;
    logic       neg;
    int         ack_dly;
    logic [6:0] exec;   // {sc_en, sc_clr, reg_exe, imm_exe, reg_to_acc, acc_to_reg, assign_val}
    logic       jump;
  } vec_t;

  typedef struct {
    logic          jump;
    logic [CW-1:0] ret_after;
  } exp_t;

  int            errors = 0;
  int            checks = 0;
  exp_t          sb[$];
  logic [CW-1:0] ret_model = '0;
  vec_t          vecs[22];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [12:0] expand(input logic [6:0] e);
    return {3'b000, e[6:3], 2'b00, e[2:0], 1'b0};
  endfunction

  function automatic vec_t mkv(input logic [3:0] op, input logic m, input logic z,
                               input logic n, input int ack, input logic [6:0] ex,
                               input logic j);
    vec_t v;
    v.op = op; v.m = m; v.zero = z; v.neg = n; v.ack_dly = ack; v.exec = ex; v.jump = j;
    return v;
  endfunction

  task automatic run_vec(input vec_t v);
    exp_t e;
    exp_t got;
    logic is_lw, is_sw, seen;
    int   lat;
    is_lw = (v.op == OP_LW);
    is_sw = (v.op == OP_SW);
    @(negedge CLK);
    chk("idle_ready", 32'(instr_ready), 1);
    Instruction = {v.op, v.m, 4'($urandom)};
    instr_valid = 1'b1;
    ZERO = ~v.zero; NEG = ~v.neg; BEVEN = 1'($urandom);
    e.jump = v.jump;
    e.ret_after = ret_model + 1'b1;
    sb.push_back(e);
    @(posedge CLK); #1;
    instr_valid = 1'b0; Instruction = '0; mem_ack = 1'b1;
    @(negedge CLK);
    chk("decode_quiet", 32'(outs), 0);
    chk("decode_busy", 32'(instr_ready), 0);
    @(posedge CLK); #1;
    mem_ack = 1'b0; ZERO = v.zero; NEG = v.neg;
    @(negedge CLK);
    chk("exec_strobes", 32'(outs), 32'(expand(v.exec)));
    @(posedge CLK); #1;
    ZERO = ~v.zero; NEG = ~v.neg;
    if (is_lw || is_sw) begin
      for (int k = 0; k <= v.ack_dly; k++) begin
        @(negedge CLK);
        chk("mem_req_hold", 32'({mem_req, reg_to_mem}), 32'({1'b1, is_sw}));
        if (k == v.ack_dly) mem_ack = 1'b1;
        @(posedge CLK); #1;
        mem_ack = 1'b0;
      end
      if (is_lw) begin
        @(negedge CLK);
        chk("wb_strobe", 32'(outs), 32'h020);
      end
    end
    seen = 1'b0;
    lat  = 0;
    for (int k = 0; k < 4 && !seen; k++) begin
      @(negedge CLK);
      if (jump_en || pc_advance) seen = 1'b1;
      else lat++;
    end
    chk("retire_latency", 32'(lat), 0);
    if (seen) begin
      got = sb.pop_front();
      chk("retire_pc", 32'({jump_en, pc_advance}), 32'({got.jump, ~got.jump}));
      chk("retire_only", 32'(outs & ~13'h0C00), 0);
      @(negedge CLK);
      chk("retired_count", 32'(retired), 32'(got.ret_after));
      chk("ready_again", 32'(instr_ready), 1);
      ret_model = got.ret_after;
    end else begin
      sb.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vecs[0]  = mkv(OP_ADD,    1, 0, 0, 0, 7'b1001000, 0);
    vecs[1]  = mkv(OP_ADD,    0, 0, 0, 0, 7'b1010000, 0);
    vecs[2]  = mkv(OP_SUB,    1, 0, 0, 0, 7'b1001000, 0);
    vecs[3]  = mkv(OP_SUB,    0, 1, 1, 0, 7'b1010000, 0);
    vecs[4]  = mkv(OP_AND,    0, 0, 0, 0, 7'b0010000, 0);
    vecs[5]  = mkv(OP_OR,     1, 0, 0, 0, 7'b0001000, 0);
    vecs[6]  = mkv(OP_BEQ,    0, 1, 0, 0, 7'b0010000, 1);
    vecs[7]  = mkv(OP_BEQ,    1, 0, 0, 0, 7'b0001000, 0);
    vecs[8]  = mkv(OP_BNE,    1, 1, 0, 0, 7'b0001000, 0);
    vecs[9]  = mkv(OP_BNE,    0, 0, 0, 0, 7'b0010000, 1);
    vecs[10] = mkv(OP_BGE,    0, 0, 0, 0, 7'b0010000, 1);
    vecs[11] = mkv(OP_BGE,    1, 0, 1, 0, 7'b0001000, 0);
    vecs[12] = mkv(OP_MOV,    0, 0, 0, 0, 7'b0000100, 0);
    vecs[13] = mkv(OP_MOV,    1, 0, 0, 0, 7'b0000010, 0);
    vecs[14] = mkv(OP_ASSIGN, 0, 0, 0, 0, 7'b0000001, 0);
    vecs[15] = mkv(OP_CLRSC,  0, 0, 0, 0, 7'b0100000, 0);
    vecs[16] = mkv(OP_JMP,    0, 0, 1, 0, 7'b0000000, 1);
    vecs[17] = mkv(4'hF,      1, 1, 0, 0, 7'b0000000, 0);
    vecs[18] = mkv(OP_LW,     0, 0, 0, 0, 7'b0000000, 0);
    vecs[19] = mkv(OP_LW,     1, 0, 0, 2, 7'b0000000, 0);
    vecs[20] = mkv(OP_SW,     0, 0, 0, 0, 7'b0000000, 0);
    vecs[21] = mkv(OP_SW,     0, 0, 0, TO - 1, 7'b0000000, 0);

    #12;
    chk("rst_outs", 32'(outs), 0);
    chk("rst_ready", 32'(instr_ready), 1);
    chk("rst_retired", 32'(retired), 0);
    @(negedge CLK);
    Reset = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Abandon an ADD in EXEC: asynchronous reset must clear everything at once.
    @(negedge CLK);
    Instruction = {OP_ADD, 1'b1, 4'h3};
    instr_valid = 1'b1;
    @(posedge CLK); #1;
    instr_valid = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    chk("pre_rst_exec", 32'(outs), 32'(expand(7'b1001000)));
    Reset = 1'b0;
    #1;
    chk("mid_rst_outs", 32'(outs), 0);
    chk("mid_rst_ready", 32'(instr_ready), 1);
    chk("mid_rst_retired", 32'(retired), 0);
    @(negedge CLK);
    Reset = 1'b1;
    for (int t = 0; t < 4; t++) begin
      @(negedge CLK);
      chk("post_rst_idle", 32'({outs, instr_ready}), 1);
    end
    ret_model = '0;

    // Five back-to-back ASSIGNs: 4-cycle cadence and a wrapping 2-bit counter.
    Instruction = {OP_ASSIGN, 1'b0, 4'h0};
    instr_valid = 1'b1;
    for (int t = 1; t <= 20; t++) begin
      @(negedge CLK);
      chk("b2b_assign", 32'(assign_val), 32'(t % 4 == 2));
      chk("b2b_pc", 32'(pc_advance), 32'(t % 4 == 3));
      chk("b2b_ready", 32'(instr_ready), 32'(t % 4 == 0));
      if (t % 4 == 0) chk("b2b_retired", 32'(retired), 32'((t / 4) % 4));
    end
    instr_valid = 1'b0;
    ret_model = 2'd1;

    // SW that never sees mem_ack: ERR after TO memory cycles, then sticky.
    @(negedge CLK);
    Instruction = {OP_SW, 1'b0, 4'h0};
    instr_valid = 1'b1;
    @(posedge CLK); #1;
    instr_valid = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    for (int k = 0; k < TO; k++) begin
      @(negedge CLK);
      chk("to_mem_hold", 32'({mem_req, reg_to_mem, err}), 32'b110);
    end
    @(negedge CLK);
    chk("to_err_outs", 32'(outs), 1);
    chk("to_err_ready", 32'(instr_ready), 0);
    instr_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      mem_ack = k[0];
      @(negedge CLK);
      chk("err_sticky", 32'({outs, instr_ready, retired}), 32'({13'h001, 1'b0, ret_model}));
    end
    instr_valid = 1'b0;
    mem_ack = 1'b0;
    Reset = 1'b0;
    #1;
    chk("err_rst_outs", 32'(outs), 0);
    chk("err_rst_ready", 32'(instr_ready), 1);
    chk("err_rst_retired", 32'(retired), 0);
    @(negedge CLK);
    Reset = 1'b1;
    ret_model = '0;
    run_vec(vecs[0]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
